// File: rtl/fx_pkg.sv
// Shared fixed-point package for the inverse-CDF pipeline: FSM state type
// and common Q16.16 constants.
package fx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fx_state_e;

    localparam logic [31:0] ONE_Q16 = 32'h0001_0000;
    localparam logic [31:0] ZERO_Q  = 32'h0000_0000;

endpackage

// File: rtl/fx_sqrt_tail.sv
// Bit-serial restoring square root of a signed Q(QINT).(QFRAC) radicand, one root bit per cycle.
// Build option: define FX_SQRT_ROUND_EN for round-to-nearest t instead of truncation.
module fx_sqrt_tail
    import fx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int QINT  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready,
    input  logic [WIDTH-1:0] x,
    input  logic             negate_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] t,
    output logic             negate,
    output logic             range_err
);

    localparam int QFRAC = WIDTH - QINT;
    localparam int RW    = WIDTH + QFRAC;
    localparam int ITER  = (WIDTH + QFRAC) / 2;
    localparam int REMW  = ITER + 2;
    localparam int CW    = $clog2(ITER);

    // Handshake: a sample transfers on a rising edge where valid_in && ready;
    // ready depends on state only, valid_out/range_err are high only in DONE.

    fx_state_e         state;
    logic [CW-1:0]     cnt;
    logic [REMW-1:0]   rem;
    logic [ITER-1:0]   root;
    logic [RW-1:0]     rad;
    logic              err_cap;
    logic              neg_cap;

    logic [REMW:0]     rem_sh;
    logic [REMW:0]     trial;
    logic              ge;
    logic [REMW-1:0]   rem_nxt;
    logic [ITER-1:0]   root_nxt;
    logic [WIDTH-1:0]  t_root;
    logic [WIDTH-1:0]  t_fin;

    always_comb begin
        ready     = (state == IDLE) || (state == DONE);
        valid_out = (state == DONE);
        range_err = (state == DONE) && err_cap;
    end

    // Stored remainder never exceeds 2*root, so its top bit is free for the shift.
    always_comb begin
        rem_sh   = {rem[REMW-2:0], rad[RW-1 -: 2]};
        trial    = {1'b0, root, 2'b01};
        ge       = (rem_sh >= trial);
        rem_nxt  = ge ? REMW'(rem_sh - trial) : REMW'(rem_sh);
        root_nxt = {root[ITER-2:0], ge};
        t_root   = {{(WIDTH-ITER){1'b0}}, root_nxt};
`ifdef FX_SQRT_ROUND_EN
        // sqrt(R) >= root + 0.5 exactly when the final remainder exceeds the root
        if ((rem_nxt > {2'b00, root_nxt}) && (t_root != {WIDTH{1'b1}}))
            t_fin = t_root + WIDTH'(1);
        else
            t_fin = t_root;
`else
        t_fin = t_root;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            root    <= '0;
            rad     <= '0;
            err_cap <= 1'b0;
            neg_cap <= 1'b0;
            t       <= '0;
            negate  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (valid_in) begin
                        state   <= CALC;
                        cnt     <= CW'(ITER - 1);
                        rem     <= '0;
                        root    <= '0;
                        rad     <= {x, {QFRAC{1'b0}}};
                        err_cap <= x[WIDTH-1];
                        neg_cap <= negate_in;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    // A negative radicand keeps root at zero but spends the same cycles.
                    if (!err_cap) begin
                        rem  <= rem_nxt;
                        root <= root_nxt;
                        rad  <= rad << 2;
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state  <= DONE;
                        t      <= err_cap ? '0 : t_fin;
                        negate <= neg_cap;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
